// File: rtl/clock_monitor_pkg.sv
// Shared types and defaults for the clock monitor.
// State encoding and default counter width used by clock_monitor.
package clock_monitor_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_e;

endpackage

// File: rtl/clock_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of a sampled clock in clock_in cycles,
// flags deviation from expected values and a stuck (edge-less) input.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int EXP_PERIOD = 3,
    parameter int EXP_HIGH   = 1,
    parameter int TOL        = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             mon_in,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_err,
    output logic             duty_err,
    output logic             stuck,
    output logic [7:0]       meas_count
);

    localparam logic [CNT_W:0]   EXP_P_C   = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   EXP_H_C   = (CNT_W+1)'(EXP_HIGH);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // One extra bit so a measurement far below the expectation cannot wrap to a pass.
    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W:0]   b);
        logic [CNT_W:0] ax;
        ax = {1'b0, a};
        return (ax >= b) ? (ax - b) : (b - ax);
    endfunction

    logic s2;
    logic prev_q, prev_d;
    logic rise;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              perr_q, perr_d;
    logic              derr_q, derr_d;
    logic              stuck_q, stuck_d;
    logic [7:0]        cnt_q, cnt_d;

    sync_2ff u_sync (
        .clk   (clock_in),
        .reset (reset),
        .d     (mon_in),
        .q     (s2)
    );

    assign rise = s2 & ~prev_q;

    always_comb begin
        prev_d   = s2;
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        hcnt_d   = hcnt_q;
        valid_d  = 1'b0;
        period_d = period_q;
        high_d   = high_q;
        perr_d   = perr_q;
        derr_d   = derr_q;
        stuck_d  = stuck_q;
        cnt_d    = cnt_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First rise only opens a window; nothing to report yet.
                    if (rise) begin
                        pcnt_d  = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        valid_d  = 1'b1;
                        period_d = pcnt_q;
                        high_d   = hcnt_q;
                        perr_d   = abs_diff(pcnt_q, EXP_P_C) > TOL_C;
                        derr_d   = abs_diff(hcnt_q, EXP_H_C) > TOL_C;
                        cnt_d    = cnt_q + 8'd1;
                        stuck_d  = 1'b0;
                        pcnt_d   = CNT_ONE;
                        hcnt_d   = CNT_ONE;
                    end else if (pcnt_q >= TIMEOUT_C) begin
                        stuck_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_ONE;
                        if (s2 && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            prev_q   <= 1'b0;
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            valid_q  <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            perr_q   <= 1'b0;
            derr_q   <= 1'b0;
            stuck_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            high_q   <= high_d;
            perr_q   <= perr_d;
            derr_q   <= derr_d;
            stuck_q  <= stuck_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid      = valid_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign period_err = perr_q;
    assign duty_err   = derr_q;
    assign stuck      = stuck_q;
    assign meas_count = cnt_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench: three monitors with different expectations share one stimulus;
// a rise-history model predicts every output each cycle, plus directed literal checks.
module tb_clock_monitor;

    localparam int CW = 16;
    localparam int TO = 16;
    localparam int ND = 3;
    localparam int HN = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic mon_in = 1'b0;

    always #5 clk = ~clk;

    logic [ND-1:0] valid_w, perr_w, derr_w, stuck_w;
    logic [CW-1:0] period_w [ND];
    logic [CW-1:0] high_w   [ND];
    logic [7:0]    cnt_w    [ND];

    // dut0: defaults; dut1: TOL=1; dut2: expects a div-by-2 clock
    clock_monitor #(.CNT_W(CW), .EXP_PERIOD(3), .EXP_HIGH(1), .TOL(0), .TIMEOUT(TO)) u_a (
        .clock_in(clk), .reset(reset), .enable(enable), .mon_in(mon_in),
        .valid(valid_w[0]), .period(period_w[0]), .high_time(high_w[0]),
        .period_err(perr_w[0]), .duty_err(derr_w[0]), .stuck(stuck_w[0]), .meas_count(cnt_w[0]));
    clock_monitor #(.CNT_W(CW), .EXP_PERIOD(3), .EXP_HIGH(1), .TOL(1), .TIMEOUT(TO)) u_b (
        .clock_in(clk), .reset(reset), .enable(enable), .mon_in(mon_in),
        .valid(valid_w[1]), .period(period_w[1]), .high_time(high_w[1]),
        .period_err(perr_w[1]), .duty_err(derr_w[1]), .stuck(stuck_w[1]), .meas_count(cnt_w[1]));
    clock_monitor #(.CNT_W(CW), .EXP_PERIOD(2), .EXP_HIGH(1), .TOL(0), .TIMEOUT(TO)) u_c (
        .clock_in(clk), .reset(reset), .enable(enable), .mon_in(mon_in),
        .valid(valid_w[2]), .period(period_w[2]), .high_time(high_w[2]),
        .period_err(perr_w[2]), .duty_err(derr_w[2]), .stuck(stuck_w[2]), .meas_count(cnt_w[2]));

    function automatic int ep(input int d);
        return (d == 2) ? 2 : 3;
    endfunction
    function automatic int eh(input int d);
        return (d < 0) ? 0 : 1;
    endfunction
    function automatic int tl(input int d);
        return (d == 1) ? 1 : 0;
    endfunction
    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // samp[n] is mon_in captured at edge n; the synchronized level seen at edge n is samp[n-2].
    bit samp [HN];
    int cyc = 3;
    bit started = 0;
    bit armed = 0;
    int last_rise = 0;
    bit m_valid = 0, m_stuck = 0;
    int m_period = 0, m_high = 0, m_count = 0;
    bit m_perr [ND];
    bit m_derr [ND];

    task automatic model_step();
        bit s2, pv, rise;
        int hsum;
        samp[cyc] = mon_in;
        if (reset) begin
            samp[cyc] = 0; samp[cyc-1] = 0; samp[cyc-2] = 0;
            started = 1; armed = 0; m_valid = 0; m_stuck = 0;
            m_period = 0; m_high = 0; m_count = 0;
            for (int d = 0; d < ND; d++) begin m_perr[d] = 0; m_derr[d] = 0; end
        end else begin
            s2 = samp[cyc-2];
            pv = samp[cyc-3];
            rise = s2 && !pv;
            m_valid = 0;
            if (!enable) begin
                armed = 0;
            end else if (!armed) begin
                if (rise) begin armed = 1; last_rise = cyc; end
            end else if (rise) begin
                hsum = 0;
                for (int k = last_rise; k < cyc; k++) hsum += samp[k-2];
                m_valid = 1;
                m_period = (cyc - last_rise > 65535) ? 65535 : cyc - last_rise;
                m_high = (hsum > 65535) ? 65535 : hsum;
                m_count = (m_count + 1) % 256;
                m_stuck = 0;
                for (int d = 0; d < ND; d++) begin
                    m_perr[d] = iabs(m_period - ep(d)) > tl(d);
                    m_derr[d] = iabs(m_high - eh(d)) > tl(d);
                end
                last_rise = cyc;
            end else if (cyc - last_rise >= TO) begin
                m_stuck = 1;
                armed = 0;
            end
        end
        cyc++;
        if (cyc >= HN) begin
            $display("FAIL model_history_overflow got=%0d want<%0d", cyc, HN);
            $fatal(1, "history exhausted");
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (valid_w[d] !== m_valid || period_w[d] !== CW'(m_period) ||
                    high_w[d] !== CW'(m_high) || perr_w[d] !== m_perr[d] ||
                    derr_w[d] !== m_derr[d] || stuck_w[d] !== m_stuck ||
                    cnt_w[d] !== 8'(m_count)) begin
                    failures++;
                    $display("FAIL model_cmp dut%0d t=%0t got v=%b p=%0d h=%0d pe=%b de=%b s=%b c=%0d want v=%b p=%0d h=%0d pe=%b de=%b s=%b c=%0d",
                             d, $time, valid_w[d], period_w[d], high_w[d], perr_w[d], derr_w[d],
                             stuck_w[d], cnt_w[d], m_valid, m_period, m_high, m_perr[d],
                             m_derr[d], m_stuck, m_count);
                end
            end
        end
    end

    // ---------------- pattern driver ----------------
    // mon_in is high for pat_h of every pat_p cycles; pat_h >= pat_p holds it high.
    int pat_p = 3, pat_h = 1, phase = 0;
    initial forever begin
        @(negedge clk);
        phase = (phase + 1) % pat_p;
        mon_in = (phase < pat_h);
    end

    task automatic set_pat(input int p, input int h);
        pat_p = p; pat_h = h; phase = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max, output int waited);
        waited = 0;
        while (waited < max) begin
            @(negedge clk);
            waited++;
            if (valid_w[0]) break;
        end
        if (!valid_w[0]) begin
            checks++; failures++;
            $display("FAIL %s_timeout got=no_valid want=valid_within_%0d", name, max);
        end
    endtask

    initial begin
        int w, c0;
        bit saw;

        // reset state
        reset = 1; enable = 0; set_pat(3, 1);
        cycles(4);
        chk("rst_valid", valid_w[0], 0);
        chk("rst_period", period_w[0], 0);
        chk("rst_high", high_w[0], 0);
        chk("rst_stuck", stuck_w[0], 0);
        chk("rst_count", cnt_w[0], 0);
        chk("rst_perr", perr_w[0], 0);

        // div-by-2
        reset = 0; enable = 1; set_pat(2, 1);
        cycles(20);
        chk("div2_period", period_w[2], 2);
        chk("div2_high", high_w[2], 1);
        chk("div2_perr_exp2", perr_w[2], 0);
        chk("div2_derr_exp2", derr_w[2], 0);
        chk("div2_perr_exp3", perr_w[0], 1);
        chk("div2_perr_tol1", perr_w[1], 0);

        // div-by-3, 33% duty: one measurement per 3 cycles
        set_pat(3, 1);
        cycles(9);
        c0 = m_count;
        cycles(30);
        chk("model_div3_rate", (m_count - c0 + 256) % 256, 10);
        chk("div3_rate", cnt_w[0], (c0 + 10) % 256);
        chk("div3_period", period_w[0], 3);
        chk("div3_high", high_w[0], 1);
        chk("div3_perr", perr_w[0], 0);
        chk("div3_derr", derr_w[0], 0);

        // div-by-4, 50% duty
        set_pat(4, 2);
        cycles(16);
        chk("div4_period", period_w[0], 4);
        chk("div4_high", high_w[0], 2);
        chk("div4_perr", perr_w[0], 1);
        chk("div4_derr", derr_w[0], 1);
        chk("div4_perr_tol1", perr_w[1], 0);
        chk("div4_derr_tol1", derr_w[1], 0);

        // stuck high
        set_pat(1, 1);
        w = 0;
        while (w < 40 && !stuck_w[0]) begin @(negedge clk); w++; end
        chk("stuck_set", stuck_w[0], 1);
        chk("model_stuck_set", m_stuck, 1);
        set_pat(3, 1);
        wait_valid("restart", 20, w);
        chk("restart_stuck_clr", stuck_w[0], 0);
        chk("restart_period", period_w[0], 3);
        chk("restart_two_rises", w >= 4, 1);

        // reset mid-period
        cycles(1);
        reset = 1;
        cycles(1);
        chk("midrst_period", period_w[0], 0);
        chk("midrst_count", cnt_w[0], 0);
        chk("midrst_valid", valid_w[0], 0);
        reset = 0;
        wait_valid("post_reset", 20, w);
        chk("post_reset_count", cnt_w[0], 1);
        chk("post_reset_period", period_w[0], 3);

        // enable dropped for 10 cycles
        enable = 0;
        saw = 0;
        repeat (10) begin @(negedge clk); if (valid_w[0]) saw = 1; end
        chk("en_low_no_valid", saw, 0);
        chk("en_low_count_hold", cnt_w[0], 1);
        chk("en_low_period_hold", period_w[0], 3);
        enable = 1;
        wait_valid("reenable", 20, w);
        chk("reenable_count", cnt_w[0], 2);
        chk("reenable_two_rises", w >= 4, 1);

        cycles(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
